// File: rtl/fpu_wb_merge.sv
// fpu_wb_merge: merges tagged results from two non-stallable FPU pipes (A = itof,
// B = another FPU unit) into one registered writeback port to the FP register file.
// Each source has its own FIFO. A round-robin pointer arbitrates when both FIFOs hold data.
// stall_x is raised early enough that LAT results still in flight always fit.
// Optional feature macro: FPU_WB_BYPASS_EN. When it is defined, a result that arrives while
// everything is idle goes straight into the output register, cutting latency from 2 to 1.
module fpu_wb_merge #(
  parameter int DEPTH  = 4,
  parameter int LAT    = 1,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              a_flag,
  input  logic [ADDR_W-1:0] a_add,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_flag,
  input  logic [ADDR_W-1:0] b_add,
  input  logic [DATA_W-1:0] b_data,
  input  logic              wb_ready,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_add,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall_a,
  output logic              stall_b,
  output logic              overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  entry_t         mem_a [DEPTH];
  entry_t         mem_b [DEPTH];
  logic [PW-1:0]  wr_a, rd_a, wr_b, rd_b;
  logic [CW-1:0]  cnt_a, cnt_b;
  src_e           rr;

  entry_t in_a, in_b, out_next;
  logic   load, ne_a, ne_b, full_a, full_b;
  logic   pop_a, pop_b, byp_a, byp_b, push_a, push_b, drop_a, drop_b;
  logic   flip, out_take;

  assign in_a = {a_add, a_data};
  assign in_b = {b_add, b_data};

  // The registered count already includes this edge's push and pop, so decoding stall
  // from it leaves room for exactly LAT more results.
  assign stall_a = (cnt_a >= CW'(DEPTH - LAT));
  assign stall_b = (cnt_b >= CW'(DEPTH - LAT));

  // Arbitration, bypass selection and push/drop decisions for the coming edge.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    load     = !wb_valid || wb_ready;
    ne_a     = (cnt_a != '0);
    ne_b     = (cnt_b != '0);
    full_a   = (cnt_a == CW'(DEPTH));
    full_b   = (cnt_b == CW'(DEPTH));
    pop_a    = load && ne_a && (!ne_b || rr == SRC_A);
    pop_b    = load && ne_b && (!ne_a || rr == SRC_B);
    flip     = load && ne_a && ne_b;
    byp_a    = 1'b0;
    byp_b    = 1'b0;
`ifdef FPU_WB_BYPASS_EN
    // Both FIFOs are empty and the output can load, so a new result skips its FIFO.
    // If both sources arrive together, the round-robin winner takes the output register.
    if (load && !ne_a && !ne_b) begin
      byp_a = a_flag && (!b_flag || rr == SRC_A);
      byp_b = b_flag && (!a_flag || rr == SRC_B);
      flip  = a_flag && b_flag;
    end
`endif
    // A full FIFO can still take a push if its head leaves on the same edge.
    push_a   = a_flag && !byp_a && (!full_a || pop_a);
    push_b   = b_flag && !byp_b && (!full_b || pop_b);
    drop_a   = a_flag && !byp_a && full_a && !pop_a;
    drop_b   = b_flag && !byp_b && full_b && !pop_b;
    out_take = pop_a || pop_b || byp_a || byp_b;
    // Pops and bypasses are mutually exclusive, because a bypass needs both FIFOs empty.
    out_next = mem_a[rd_a];
    if (pop_b) out_next = mem_b[rd_b];
    if (byp_a) out_next = in_a;
    if (byp_b) out_next = in_b;
  end

  // FIFO storage: written only, never cleared.
  always_ff @(posedge clk) begin
    // NOTE: the storage arrays have no reset; the pointers and counts decide which entries are valid, so clearing them adds nothing.
    if (push_a) mem_a[wr_a] <= in_a;
    if (push_b) mem_b[wr_b] <= in_b;
  end

  // FIFO pointers and occupancy counts. Pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
    if (!rstn) begin
      wr_a  <= '0;
      rd_a  <= '0;
      cnt_a <= '0;
      wr_b  <= '0;
      rd_b  <= '0;
      cnt_b <= '0;
    end else begin
      if (push_a) wr_a <= wr_a + PW'(1);
      if (pop_a)  rd_a <= rd_a + PW'(1);
      if (push_b) wr_b <= wr_b + PW'(1);
      if (pop_b)  rd_b <= rd_b + PW'(1);
      cnt_a <= cnt_a + CW'(push_a) - CW'(pop_a);
      cnt_b <= cnt_b + CW'(push_b) - CW'(pop_b);
    end
  end

  // Writeback output register. It holds while a beat is offered and not accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid <= 1'b0;
      wb_add   <= '0;
      wb_data  <= '0;
    end else if (load) begin
      wb_valid <= out_take;
      if (out_take) begin
        wb_add  <= out_next.add;
        wb_data <= out_next.data;
      end
    end
  end

  // Round-robin pointer (moves only on a contended grant) and the sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr       <= SRC_A;
      overflow <= 1'b0;
    end else begin
      if (flip) rr <= (rr == SRC_A) ? SRC_B : SRC_A;
      if (drop_a || drop_b) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_wb_merge.sv
// Directed self-checking bench for fpu_wb_merge (DEPTH=4, LAT=1).
// Completed beats are captured into a queue and compared against values worked out by hand.
module tb_fpu_wb_merge;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;
  localparam int AW    = 5;
  localparam int DW    = 32;
`ifdef FPU_WB_BYPASS_EN
  localparam int WB_LAT = 1;
`else
  localparam int WB_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          a_flag, b_flag, wb_ready;
  logic [AW-1:0] a_add, b_add;
  logic [DW-1:0] a_data, b_data;
  logic          wb_valid, stall_a, stall_b, overflow;
  logic [AW-1:0] wb_add;
  logic [DW-1:0] wb_data;

  int checks = 0;
  int errors = 0;

  typedef logic [AW+DW-1:0] beat_t;
  beat_t beats[$];

  fpu_wb_merge #(.DEPTH(DEPTH), .LAT(LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn),
    .a_flag(a_flag), .a_add(a_add), .a_data(a_data),
    .b_flag(b_flag), .b_add(b_add), .b_data(b_data),
    .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_add(wb_add), .wb_data(wb_data),
    .stall_a(stall_a), .stall_b(stall_b), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk_data(input logic src_b, input logic [AW-1:0] add);
    return (src_b ? 32'hB000_0000 : 32'hA000_0000) | {{(DW-AW){1'b0}}, add};
  endfunction

  // Record a beat if one completes at the next edge, then advance to just after that edge.
  task automatic step();
    if (wb_valid && wb_ready) beats.push_back({wb_add, wb_data});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_flag = 1'b0; a_add = '0; a_data = '0;
    b_flag = 1'b0; b_add = '0; b_data = '0;
  endtask

  // Model two LAT=1 pipes. An issue happens only while stall is low, and its result
  // shows up one edge later. A starts at addr 0 and B at addr 16.
  task automatic run_pipes(input int na, input int nb, input bit toggle, output bit done);
    int ia = 0, ib = 0, pa = 0, pb = 0;
    bit iss_a = 0, iss_b = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_flag = iss_a; a_add = AW'(pa);      a_data = mk_data(1'b0, AW'(pa));
      b_flag = iss_b; b_add = AW'(16 + pb); b_data = mk_data(1'b1, AW'(16 + pb));
      if (iss_a) pa++;
      if (iss_b) pb++;
      iss_a = (ia < na) && !stall_a;
      iss_b = (ib < nb) && !stall_b;
      if (iss_a) ia++;
      if (iss_b) ib++;
      wb_ready = toggle ? cyc[0] : 1'b1;
      step();
      if (beats.size() == na + nb) begin
        done = 1'b1;
        break;
      end
    end
    idle_inputs();
    wb_ready = 1'b1;
  endtask

  // Hold the output register with one B result (addr 9) while wb_ready is low.
  task automatic preload_b();
    wb_ready = 1'b0;
    b_flag = 1'b1; b_add = 5'd9; b_data = mk_data(1'b1, 5'd9);
    step();
    b_flag = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    wb_ready = 1'b0;
    #12;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
    checks++; if (wb_add !== '0) begin errors++; $display("FAIL reset_wb_add got %0d want 0", wb_add); end
    checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
    checks++; if ({stall_a, stall_b} !== 2'b00) begin errors++; $display("FAIL reset_stall got %b want 00", {stall_a, stall_b}); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    int first = -1;
    beats.delete();
    wb_ready = 1'b1;
    a_flag = 1'b1; a_add = 5'd3; a_data = 32'h3F80_0000;
    b_flag = 1'b0; b_add = 5'h1F; b_data = 32'hDEAD_BEEF;
    step();
    a_flag = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (wb_valid && first < 0) first = i;
      step();
    end
    checks++; if (first != WB_LAT) begin errors++; $display("FAIL single_latency got %0d want %0d", first, WB_LAT); end
    checks++; if (beats.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", beats.size()); end
    if (beats.size() > 0) begin
      checks++;
      if (beats[0] !== {5'd3, 32'h3F80_0000}) begin
        errors++; $display("FAIL single_beat got %h want %h", beats[0], {5'd3, 32'h3F80_0000});
      end
    end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", wb_valid); end
  endtask

  task automatic test_contention();
    bit done;
    beat_t exp;
    beats.delete();
    run_pipes(8, 8, 1'b0, done);
    checks++; if (!done) begin errors++; $display("FAIL contention_timeout got %0d beats want 16", beats.size()); end
    checks++; if (beats.size() != 16) begin errors++; $display("FAIL contention_count got %0d want 16", beats.size()); end
    for (int i = 0; i < beats.size() && i < 16; i++) begin
      exp = (i % 2 == 0) ? {AW'(i / 2), mk_data(1'b0, AW'(i / 2))}
                         : {AW'(16 + i / 2), mk_data(1'b1, AW'(16 + i / 2))};
      checks++;
      if (beats[i] !== exp) begin errors++; $display("FAIL contention_beat%0d got %h want %h", i, beats[i], exp); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL contention_overflow got %b want 0", overflow); end
  endtask

  task automatic test_back_pressure();
    beat_t exp;
    beats.delete();
    preload_b();
    for (int i = 0; i < 4; i++) begin
      a_flag = 1'b1; a_add = AW'(i); a_data = mk_data(1'b0, AW'(i));
      step();
      checks++;
      if (stall_a !== logic'(i + 1 >= DEPTH - LAT)) begin
        errors++; $display("FAIL bp_stall_a push%0d got %b want %b", i, stall_a, logic'(i + 1 >= DEPTH - LAT));
      end
      checks++;
      if ({wb_valid, wb_add, wb_data} !== {1'b1, 5'd9, mk_data(1'b1, 5'd9)}) begin
        errors++; $display("FAIL bp_hold push%0d got %b/%0d/%h want 1/9/%h", i, wb_valid, wb_add, wb_data, mk_data(1'b1, 5'd9));
      end
    end
    a_flag = 1'b0;
    wb_ready = 1'b1;
    repeat (8) step();
    checks++; if (beats.size() != 5) begin errors++; $display("FAIL bp_count got %0d want 5", beats.size()); end
    for (int i = 0; i < beats.size() && i < 5; i++) begin
      exp = (i == 0) ? {5'd9, mk_data(1'b1, 5'd9)} : {AW'(i - 1), mk_data(1'b0, AW'(i - 1))};
      checks++;
      if (beats[i] !== exp) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, beats[i], exp); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    beat_t exp;
    beats.delete();
    preload_b();
    for (int i = 0; i < 6; i++) begin
      a_flag = 1'b1; a_add = AW'(i); a_data = mk_data(1'b0, AW'(i));
      step();
      checks++;
      if (overflow !== logic'(i >= DEPTH)) begin
        errors++; $display("FAIL ovf_flag push%0d got %b want %b", i, overflow, logic'(i >= DEPTH));
      end
    end
    a_flag = 1'b0;
    wb_ready = 1'b1;
    repeat (8) step();
    checks++; if (beats.size() != 5) begin errors++; $display("FAIL ovf_count got %0d want 5", beats.size()); end
    for (int i = 0; i < beats.size() && i < 5; i++) begin
      exp = (i == 0) ? {5'd9, mk_data(1'b1, 5'd9)} : {AW'(i - 1), mk_data(1'b0, AW'(i - 1))};
      checks++;
      if (beats[i] !== exp) begin errors++; $display("FAIL ovf_beat%0d got %h want %h", i, beats[i], exp); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_reset_midstream();
    preload_b();
    for (int i = 0; i < 3; i++) begin
      a_flag = 1'b1; a_add = AW'(i); a_data = mk_data(1'b0, AW'(i));
      step();
    end
    a_flag = 1'b0;
    checks++;
    if ({wb_valid, stall_a} !== 2'b11) begin errors++; $display("FAIL mid_pre got valid/stall %b want 11", {wb_valid, stall_a}); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({wb_valid, stall_a, stall_b, overflow} !== 4'b0000) begin
      errors++; $display("FAIL mid_async got valid/sa/sb/ovf %b want 0000", {wb_valid, stall_a, stall_b, overflow});
    end
    @(negedge clk);
    rstn = 1'b1;
    beats.delete();
    wb_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (wb_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cycle%0d got %b want 0", i, wb_valid); end
    end
    checks++; if (beats.size() != 0) begin errors++; $display("FAIL mid_beats got %0d want 0", beats.size()); end
  endtask

  task automatic test_wrap();
    bit done;
    beat_t exp;
    beats.delete();
    run_pipes(0, 3 * DEPTH, 1'b1, done);
    checks++; if (!done) begin errors++; $display("FAIL wrap_timeout got %0d beats want %0d", beats.size(), 3 * DEPTH); end
    checks++; if (beats.size() != 3 * DEPTH) begin errors++; $display("FAIL wrap_count got %0d want %0d", beats.size(), 3 * DEPTH); end
    for (int i = 0; i < beats.size() && i < 3 * DEPTH; i++) begin
      exp = {AW'(16 + i), mk_data(1'b1, AW'(16 + i))};
      checks++;
      if (beats[i] !== exp) begin errors++; $display("FAIL wrap_beat%0d got %h want %h", i, beats[i], exp); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got %b want 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_overflow();
    test_reset_midstream();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
